instr_fetch_unit: RTL and testbench

Producer side of the fetch-to-decode instruction queue. Reads instruction words from the instruction memory port one word at a time and assembles them into a bundle of FETCH_NUM {pc, instr} slots. Pushes each complete bundle into the instruction queue using its push/full handshake. On a mispredict it redirects to the supplied target and discards any in-flight or assembled work.

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words one at a time, groups FETCH_NUM of them
// into a {pc, instr} bundle and pushes it to the decode queue; mispredicts redirect fetch.
`default_nettype none

module instr_fetch_unit #(
  parameter int          FETCH_NUM = 2,
  parameter logic [31:0] RESET_PC  = 32'h1eceb000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mispredict,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     imem_resp,
  output logic                     push,
  input  logic                     full,
  output logic [64*FETCH_NUM-1:0]  bundle
);

  localparam int               IDX_W        = $clog2(FETCH_NUM) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FETCH_NUM - 1);
  localparam logic [31:0]      BUNDLE_BYTES = 32'(4 * FETCH_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt;
  logic [31:0]      inflight_addr, inflight_addr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [31:0]      fetch_addr;
  logic [31:0]      target;
  logic             slot_wr;

  assign target     = redirect_pc & 32'hffff_fffc;
  assign fetch_addr = fetch_pc + (32'(idx) << 2);

  always_comb begin
    state_nxt         = state;
    fetch_pc_nxt      = fetch_pc;
    idx_nxt           = idx;
    inflight_addr_nxt = inflight_addr;
    slot_wr           = 1'b0;
    imem_req          = 1'b0;
    imem_addr         = fetch_addr;
    push              = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        idx_nxt   = '0;
        if (mispredict) fetch_pc_nxt = target;
      end

      FETCH: begin
        imem_req          = 1'b1;
        inflight_addr_nxt = fetch_addr;
        if (mispredict) begin
          fetch_pc_nxt = target;
          idx_nxt      = '0;
          // A request still in flight must be drained before the new address can go out.
          state_nxt    = imem_resp ? FETCH : FLUSH;
        end else if (imem_resp) begin
          slot_wr = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = PUSH;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      PUSH: begin
        push = !full && !mispredict;
        if (mispredict) begin
          fetch_pc_nxt = target;
          state_nxt    = FETCH;
        end else if (!full) begin
          fetch_pc_nxt = fetch_pc + BUNDLE_BYTES;
          state_nxt    = FETCH;
        end
      end

      FLUSH: begin
        imem_req  = 1'b1;
        imem_addr = inflight_addr;
        if (mispredict) fetch_pc_nxt = target;
        if (imem_resp)  state_nxt    = FETCH;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      idx           <= '0;
      inflight_addr <= RESET_PC;
    end else begin
      state         <= state_nxt;
      fetch_pc      <= fetch_pc_nxt;
      idx           <= idx_nxt;
      inflight_addr <= inflight_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle <= '0;
    end else begin
      for (int i = 0; i < FETCH_NUM; i++) begin
        if (slot_wr && (idx == IDX_W'(i))) bundle[64*i +: 64] <= {fetch_addr, imem_rdata};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level fetch model and a variable-latency memory.
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam int          N   = 2;
  localparam logic [31:0] RPC = 32'h1eceb000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mispredict = 1'b0;
  logic [31:0]    redirect_pc = '0;
  logic           imem_req;
  logic [31:0]    imem_addr;
  logic [31:0]    imem_rdata = '0;
  logic           imem_resp = 1'b0;
  logic           push;
  logic           full = 1'b0;
  logic [64*N-1:0] bundle;

  instr_fetch_unit #(.FETCH_NUM(N), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .push(push), .full(full), .bundle(bundle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Memory model: one outstanding request, response after mem_lat cycles.
  bit          mem_active = 0;
  int          mem_cnt = 0, mem_lat = 1;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] mem_addr = '0;

  // Fetch model: base address of the bundle being built, words collected so far.
  logic [31:0] m_base;
  logic [63:0] m_slots[$];
  bit          m_idle, m_drain;
  logic [31:0] m_drain_addr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_base = RPC;
    m_slots.delete();
    m_idle = 1;
    m_drain = 0;
    m_drain_addr = '0;
  endtask

  function automatic bit resp_due();
    return mem_active && (mem_cnt == mem_lat);
  endfunction

  function automatic bit collecting();
    return !m_idle && !m_drain && (m_slots.size() < N);
  endfunction

  function automatic bit cond(input int k);
    case (k)
      0:       return !m_idle && !m_drain && (m_slots.size() == N);
      1:       return collecting() && mem_active && !resp_due() && (mem_lat == 3);
      default: return collecting() && resp_due() && (m_slots.size() == N - 1);
    endcase
  endfunction

  task automatic cycle(input logic r, input logic f, input logic mp, input logic [31:0] rpc);
    logic [31:0]     exp_addr;
    logic [31:0]     tgt;
    logic            exp_req, exp_push;
    logic [64*N-1:0] exp_b;
    rst         = r;
    full        = f;
    mispredict  = mp;
    redirect_pc = rpc;
    tgt         = rpc & 32'hffff_fffc;
    imem_resp   = resp_due();
    imem_rdata  = imem_resp ? (mem_addr ^ 32'hffff_ffff) : $urandom();
    #1;
    if (r) model_reset();
    exp_req  = !r && !m_idle && (m_drain || m_slots.size() < N);
    exp_push = !r && !m_idle && !m_drain && (m_slots.size() == N) && !f && !mp;
    exp_addr = m_drain ? m_drain_addr : m_base + 32'(4 * m_slots.size());
    chk("imem_req", imem_req, exp_req);
    chk("push", push, exp_push);
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    if (exp_push) begin
      exp_b = '0;
      for (int i = 0; i < N; i++) exp_b[64*i +: 64] = m_slots[i];
      chk("bundle", bundle, exp_b);
    end
    if (!r) begin
      if (m_idle) begin
        m_idle = 0;
        if (mp) m_base = tgt;
      end else if (m_drain) begin
        if (mp) m_base = tgt;
        if (imem_resp) m_drain = 0;
      end else if (m_slots.size() == N) begin
        if (mp) begin
          m_slots.delete();
          m_base = tgt;
        end else if (!f) begin
          m_slots.delete();
          m_base = m_base + 32'(4 * N);
        end
      end else if (mp) begin
        m_slots.delete();
        m_base = tgt;
        if (!imem_resp) begin
          m_drain      = 1;
          m_drain_addr = exp_addr;
        end
      end else if (imem_resp) begin
        m_slots.push_back({exp_addr, imem_rdata});
      end
    end
    if (imem_resp) mem_active = 0;
    else if (mem_active) mem_cnt++;
    else if (imem_req && !r) begin
      mem_active = 1;
      mem_cnt    = 1;
      mem_addr   = imem_addr;
      mem_lat    = $urandom_range(lat_max, lat_min);
    end
    @(negedge clk);
  endtask

  task automatic advance_to(input int k, input string tag);
    int n = 0;
    while (!cond(k) && n < 60) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    if (!cond(k)) begin
      n_checks++;
      n_fail++;
      $error("FAIL timeout_%s: observed not reached expected reached", tag);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("reset_addr", imem_addr, RPC);
    chk("reset_bundle", bundle, '0);

    // Plain streaming with a 1-cycle memory.
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '0);

    // Queue full while a bundle waits, then drains.
    advance_to(0, "push_full");
    repeat (5) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, '0);

    // Mispredict with a 3-cycle request outstanding.
    lat_min = 3; lat_max = 3;
    advance_to(1, "mp_inflight");
    cycle(1'b0, 1'b0, 1'b1, 32'h1eceb100);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, '0);

    // Mispredict coinciding with the last slot's response.
    lat_min = 1; lat_max = 1;
    advance_to(2, "mp_resp");
    cycle(1'b0, 1'b0, 1'b1, 32'h2000_0043);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);

    // Mispredict while the bundle waits on a full queue.
    advance_to(0, "mp_push");
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 32'h3000_0010);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);

    // Reset while a response is pending.
    lat_min = 3; lat_max = 3;
    advance_to(1, "rst_fetch");
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);
    lat_min = 1; lat_max = 1;
    repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);

    // Random traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(999) == 0), ($urandom_range(9) < 3),
            ($urandom_range(19) == 0), $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
